shift_add_mul_ctrl: RTL
=======================

SHIFT_ADD_MUL_CTRL -- requirements
Module: shift_add_mul_ctrl

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 4 bits to match the 4-bit ALU datapath.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  request to multiply; sampled only in IDLE.
REQ-006 multiplicand  in  4  unsigned operand M; captured on accepted start.
REQ-007 multiplier  in  4  unsigned operand Q; captured on accepted start.
REQ-008 busy  out  1  high in ADD and SHIFT states.
REQ-009 done  out  1  one-cycle pulse in DONE state.
REQ-010 product  out  8  registered unsigned M*Q.
REQ-011 alu_sel  out  4  opcode currently driven into the ALU, for observation.

Function
REQ-012 States SHALL be IDLE, ADD, SHIFT and DONE.
REQ-013 IDLE with start=1: M<=multiplicand, Q<=multiplier, P_hi<=0, C<=0, count<=0, next state ADD.
REQ-014 IDLE with start=0: the block SHALL hold all registers and stay in IDLE.
REQ-015 The ALU opcode SHALL be 4'b0000 (A+B) with Cin=0, A=P_hi and B=M in every state except SHIFT.
REQ-016 The ALU opcode SHALL be 4'b1000 (A>>1) with A=P_hi in SHIFT.
REQ-017 ADD with Q[0]=1: {C,P_hi}<={ALU Cout, ALU result}; next state SHIFT.
REQ-018 ADD with Q[0]=0: P_hi SHALL be held, C<=0; next state SHIFT. ADD SHALL always last exactly one cycle.
REQ-019 SHIFT: P_hi<={C, ALU result[2:0]}, Q<={P_hi[0], Q[3:1]}, C<=0, count<=count+1.
REQ-020 SHIFT exit: next state SHALL be DONE when count was 3 before increment, else ADD; count width SHALL be 2 bits plus terminal detect, with no wrap into a fifth iteration.
REQ-021 On the SHIFT->DONE transition, product<={P_hi_next, Q_next}.
REQ-022 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-023 Latency SHALL be fixed regardless of operand values: start accepted at edge 0, done high in cycle 9 (after edge 8).
REQ-024 product SHALL hold its value from DONE until the next DONE, and SHALL remain stable while busy.
REQ-025 start SHALL be ignored in ADD, SHIFT and DONE; no request SHALL be queued.
REQ-026 No arithmetic overflow SHALL be possible: the product of two 4-bit operands is at most 225 and fits in 8 bits.

Reset
REQ-027 rst=1 at a clock edge SHALL force: state IDLE, busy 0, done 0, product 8'h00, alu_sel 4'b0000, M/Q/P_hi/C/count 0.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse, and SHALL clear product.
REQ-029 Reset SHALL take priority over start in the same cycle.

Structure
REQ-030 Package shift_mul_pkg SHALL hold: state enumeration, OP_ADD=4'b0000, OP_SHR=4'b1000, NUM_ITER=4.
REQ-031 The block SHALL instantiate exactly one existing sub-module, shiftALU; all add and shift arithmetic on P_hi SHALL pass through it.
REQ-032 The Q shift and the C/P_hi[0] bit routing SHALL be done in controller registers.

Verification
REQ-033 Multiply 15 x 15: start=1 in IDLE -> done in cycle 9, product=8'hE1; busy high in cycles 1-8.
REQ-034 Multiply 13 x 11 and 0 x 9: product 8'h8F and 8'h00; latency identical (9 cycles).
REQ-035 Multiply 1 x 8 and 8 x 1: product 8'h08 both; alu_sel alternates 0000/1000 in cycles 1-8.
REQ-036 Start for 5 x 5 in cycle 3 of a 7 x 3 operation -> ignored; product=8'h15, done pulses once.
REQ-037 rst=1 in cycle 5 of an operation -> IDLE next cycle, product=8'h00, no done.
REQ-038 Back-to-back: start held high continuously -> new operation accepted in the IDLE cycle after DONE; done pulses every 10 cycles.

Source files
------------

// File: rtl/shift_mul_pkg.sv
// Shared types and constants for the 4-bit shift-and-add multiplier controller.
package shift_mul_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SHR   = 4'b1000;
  localparam int         NUM_ITER = 4;
endpackage

// File: rtl/shift_add_mul_ctrl_alu.sv
// 4-bit ALU slice shared with the datapath: add with carry and logical shift right.
module shiftALU
  import shift_mul_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  input  logic [3:0] i_op,
  output logic [3:0] o_result,
  output logic       o_cout
);

  logic [4:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};

  always_comb begin
    o_result = i_a;
    o_cout   = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result = w_sum[3:0];
        o_cout   = w_sum[4];
      end
      OP_SHR: begin
        o_result = {1'b0, i_a[3:1]};
        o_cout   = i_a[0];
      end
      default: begin
        o_result = i_a;
        o_cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 4x4 unsigned multiplier: one ADD/SHIFT pair per multiplier bit,
// fixed 9-cycle latency from start to done, arithmetic on P_hi through shiftALU.
module shift_add_mul_ctrl
  import shift_mul_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [3:0] alu_sel
);

  state_t     r_state;
  logic [3:0] r_m;
  logic [3:0] r_q;
  logic [3:0] r_p_hi;
  logic       r_c;
  logic [1:0] r_count;
  logic       r_busy;
  logic       r_done;
  logic [7:0] r_product;
  logic [3:0] r_alu_sel;

  logic [3:0] w_alu_op;
  logic [3:0] w_alu_res;
  logic       w_alu_cout;
  logic [3:0] w_p_hi_shift;
  logic [3:0] w_q_shift;
  logic       w_last_iter;

  assign w_alu_op     = (r_state == ST_SHIFT) ? OP_SHR : OP_ADD;
  // Carry re-enters at the top of P_hi; P_hi LSB drops into the top of Q.
  assign w_p_hi_shift = {r_c, w_alu_res[2:0]};
  assign w_q_shift    = {r_p_hi[0], r_q[3:1]};
  assign w_last_iter  = (r_count == 2'(NUM_ITER - 1));

  shiftALU u_alu (
    .i_a      (r_p_hi),
    .i_b      (r_m),
    .i_cin    (1'b0),
    .i_op     (w_alu_op),
    .o_result (w_alu_res),
    .o_cout   (w_alu_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_m       <= 4'h0;
      r_q       <= 4'h0;
      r_p_hi    <= 4'h0;
      r_c       <= 1'b0;
      r_count   <= 2'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= 8'h00;
      r_alu_sel <= OP_ADD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_m       <= multiplicand;
            r_q       <= multiplier;
            r_p_hi    <= 4'h0;
            r_c       <= 1'b0;
            r_count   <= 2'd0;
            r_busy    <= 1'b1;
            r_alu_sel <= OP_ADD;
            r_state   <= ST_ADD;
          end
        end
        ST_ADD: begin
          if (r_q[0]) begin
            {r_c, r_p_hi} <= {w_alu_cout, w_alu_res};
          end else begin
            r_c <= 1'b0;
          end
          r_alu_sel <= OP_SHR;
          r_state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_p_hi    <= w_p_hi_shift;
          r_q       <= w_q_shift;
          r_c       <= 1'b0;
          r_count   <= r_count + 2'd1;
          r_alu_sel <= OP_ADD;
          if (w_last_iter) begin
            r_product <= {w_p_hi_shift, w_q_shift};
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_state   <= ST_ADD;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
  assign alu_sel = r_alu_sel;

endmodule
